// File: rtl/bus_pkg.sv
// Shared definitions for the two-requester bus arbiter: state encoding,
// requester identifiers and the default bus width.
package bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN1 = 2'd1;
    localparam logic [1:0] ST_OWN2 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        OWN1 = ST_OWN1,
        OWN2 = ST_OWN2
    } state_t;

    // Identifiers of the requester that most recently released the bus
    localparam logic REQ_1 = 1'b0;
    localparam logic REQ_2 = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bus_mux2.sv
// Combinational 2:1 bus select: sel=0 picks in_1, sel=1 picks in_2.
module bus_mux2 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // Plain select; the registered stage lives in the arbiter
    always_comb begin
        out = sel ? in_2 : in_1;
    end

endmodule

// File: rtl/bus_arb2.sv
// Two-requester bus arbiter: round-robin tie-break, bounded hold time while
// the other side waits, and a registered copy of the owner's data on bus_out.
module bus_arb2
    import bus_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_1,
    input  logic             req_2,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    output logic             gnt_1,
    output logic             gnt_2,
    output logic             sel,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]  bus_out_q, bus_out_d;
    logic              bus_valid_q, bus_valid_d;
    logic [WIDTH-1:0]  mux_out;

    // Select path follows the registered owner so data and grant stay aligned
    bus_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in_1 (data_1),
        .in_2 (data_2),
        .sel  (state_q == OWN2),
        .out  (mux_out)
    );

    // State, tie-break memory, hold counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= REQ_2;
            hold_cnt_q  <= '0;
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    // Next owner, tie-break memory and hold counter
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_1 && req_2) begin
                    state_d = (last_q == REQ_1) ? OWN2 : OWN1;
                end else if (req_1) begin
                    state_d = OWN1;
                end else if (req_2) begin
                    state_d = OWN2;
                end
            end
            OWN1: begin
                if (!req_1) begin
                    state_d = req_2 ? OWN2 : IDLE;
                end else if (req_2 && (hold_cnt_q == HOLD_MAX)) begin
                    state_d = OWN2;
                end
            end
            OWN2: begin
                if (!req_2) begin
                    state_d = req_1 ? OWN1 : IDLE;
                end else if (req_1 && (hold_cnt_q == HOLD_MAX)) begin
                    state_d = OWN1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Remember who just gave up the bus so the next tie goes the other way
        if ((state_q != IDLE) && (state_d != state_q)) begin
            last_d = (state_q == OWN1) ? REQ_1 : REQ_2;
        end

        // Counter restarts on every new ownership and saturates, never wraps
        if (state_d == IDLE) begin
            hold_cnt_d = '0;
        end else if (state_d != state_q) begin
            hold_cnt_d = HW'(1);
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    // Capture the current owner's data; hold the last value while idle
    always_comb begin
        bus_valid_d = (state_q != IDLE);
        bus_out_d   = (state_q != IDLE) ? mux_out : bus_out_q;
    end

    assign gnt_1     = (state_q == OWN1);
    assign gnt_2     = (state_q == OWN2);
    assign sel       = (state_q == OWN2);
    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;

endmodule
